mc_mem_responder: RTL
=====================

Name: mc_mem_responder

Overview:
- Word-addressed unified instruction/data memory that serves the multicycle datapath's memory port.
- Responds to memread/memwrite strobes with a configurable number of wait states.
- Signals completion with a one-cycle mem_ready pulse.
- Sits between the controller/datapath address mux (IorD) and the storage array, enabling non-single-cycle memory timing.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width.
- LATENCY, 2, wait cycles inserted before completion (legal range 0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- memread  input  1  read request strobe.
- memwrite  input  1  write request strobe.
- adr  input  ADDR_W  byte address; word index = adr[log2(DEPTH)+1:2].
- writedata  input  DATA_W  store data.
- readdata  output  DATA_W  registered read data.
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  request in flight; new requests ignored.
- err  output  1  misalignment flag (see Optional Feature).

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, counter=0, readdata=0, mem_ready=0, busy=0, err=0.
- The array is not reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - At a rising edge E0 with memread|memwrite=1, latch adr, writedata and op.
  - Next state is WAIT with counter=LATENCY-1 if LATENCY>0, else DONE.
- Simultaneous memread and memwrite: treated as a write only; no read is performed.
- WAIT:
  - Counter decrements each edge.
  - At an edge with counter=0, go to DONE.
  - Strobes are ignored.
- DONE entry edge (the edge at E0+LATENCY):
  - Read: readdata <= array[index].
  - Write: array[index] <= latched writedata; readdata unchanged.
- DONE:
  - mem_ready=1 for exactly one cycle, then IDLE.
  - A request present during the DONE cycle is ignored; the requester must hold its strobe.
  - The next accept occurs no earlier than the following IDLE edge.
- busy=1 in WAIT and DONE; 0 in IDLE.
- Latency: mem_ready is high in the cycle after edge E0+LATENCY.
  - LATENCY=0: the pulse occurs in the cycle right after the accepting edge.
  - Back-to-back requests: minimum period LATENCY+2 cycles.
- Address wrap: upper address bits above the index are ignored, so access is modulo DEPTH words.
- readdata holds its last value until the next completed read.
- Reset mid-operation: the request is aborted, no mem_ready is issued, and state returns to IDLE.
  - A write is committed only if its DONE entry edge preceded the reset edge.
- Strobes that drop during WAIT do not cancel the request.

Optional Feature:
- Macro: MC_MEM_ALIGN_CHECK_EN.
- Defined:
  - A request with latched adr[1:0]!=0 follows normal timing (WAIT/DONE, mem_ready pulse).
  - The array is not written and readdata is not updated.
  - err=1 in the same cycle as mem_ready, otherwise 0.
- Not defined:
  - adr[1:0] is ignored, so a misaligned address accesses the enclosing word.
  - err is tied to 0.

Test Plan:
- Reset, then write 0xDEADBEEF at adr 0x10 with LATENCY=2 → busy rises after the accept edge; mem_ready pulses in the cycle after edge E0+2; a later read of 0x10 returns 0xDEADBEEF with mem_ready after the same delay.
- LATENCY=0: read adr 0x10 → mem_ready and readdata=0xDEADBEEF in the cycle after the accept edge; back-to-back reads complete every 2 cycles.
- Write 0x12345678 to adr 0x0 and adr 4*DEPTH (wrap) → reading adr 0x0 returns the second value.
- memread and memwrite both high, adr 0x20, writedata 0xA5A5A5A5 → treated as a write; readdata unchanged; a subsequent read of 0x20 returns 0xA5A5A5A5.
- Assert reset during WAIT of a write 0x55 to adr 0x30 → no mem_ready pulse; the word at 0x30 keeps its prior value; busy=0 and readdata=0 after reset.
- With MC_MEM_ALIGN_CHECK_EN: write to adr 0x31 → err=1 coincident with mem_ready; the word at 0x30 is unchanged. Without the macro, the same write updates word 0x30 and err stays 0.

Source files
------------

// File: rtl/mc_mem_responder.sv
// mc_mem_responder: word-addressed unified instruction/data memory for the
// multicycle datapath. It accepts a memread/memwrite strobe in IDLE, waits
// LATENCY cycles, and then completes the access with a one-cycle mem_ready
// pulse. busy is high while a request is in flight.
// Optional feature: define MC_MEM_ALIGN_CHECK_EN to flag misaligned requests
// (adr[1:0] != 0). A flagged request keeps its timing, does not touch the
// array or readdata, and raises err together with mem_ready. Without the
// macro, adr[1:0] is ignored and err stays 0.
module mc_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

`ifdef MC_MEM_ALIGN_CHECK_EN
  localparam logic ALIGN_CHK = 1'b1;
`else
  localparam logic ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wr;
  logic                r_mis;
  logic [DATA_W-1:0]   r_readdata;
  logic                r_mem_ready;
  logic                r_busy;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req;
  logic                w_accept;
  logic                w_access;
  logic [IDX_W-1:0]    w_acc_idx;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_acc_wr;
  logic                w_acc_mis;
  logic                w_blocked;
  logic                w_unused;

  // Upper address bits wrap (modulo DEPTH); adr[1:0] only matters with the check.
  assign w_unused = &{1'b0, adr};

  // Select the access operands. With LATENCY=0 the access happens on the
  // accepting edge itself, so the live inputs are used instead of the latches.
  always_comb begin
    w_req    = memread | memwrite;
    w_accept = (r_state == S_IDLE) && w_req;
    if (r_state == S_IDLE) begin
      w_acc_idx   = adr[IDX_W+1:2];
      w_acc_wdata = writedata;
      w_acc_wr    = memwrite;
      w_acc_mis   = |adr[1:0];
    end else begin
      w_acc_idx   = r_idx;
      w_acc_wdata = r_wdata;
      w_acc_wr    = r_wr;
      w_acc_mis   = r_mis;
    end
    w_access  = (LATENCY == 0) ? w_accept : ((r_state == S_WAIT) && (r_cnt == '0));
    w_blocked = ALIGN_CHK & w_acc_mis;
  end

  // Control FSM with registered outputs; the access completes on DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_readdata  <= '0;
      r_mem_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_ready <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_idx   <= adr[IDX_W+1:2];
            r_wdata <= writedata;
            r_wr    <= memwrite;
            r_mis   <= |adr[1:0];
            r_busy  <= 1'b1;
            r_cnt   <= CNT_INIT;
            r_state <= (LATENCY == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_DONE;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_access) begin
        r_mem_ready <= 1'b1;
        r_err       <= w_blocked;
        if (!w_acc_wr && !w_blocked) r_readdata <= r_mem[w_acc_idx];
      end
    end
  end

  // Storage array write port; not reset, and a reset edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && w_access && w_acc_wr && !w_blocked) r_mem[w_acc_idx] <= w_acc_wdata;
  end

  assign readdata  = r_readdata;
  assign mem_ready = r_mem_ready;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
